// File: rtl/seq_gen_1011_if.sv
// seq_gen_1011_if: word handshake plus framed serial output of the 1011 frame transmitter
interface seq_gen_1011_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             out_bit;
    logic             out_valid;
    logic             frame_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, out_bit, out_valid, frame_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, out_bit, out_valid, frame_done
    );
endinterface

// File: rtl/seq_gen_1011.sv
// seq_gen_1011: sends each accepted word as a 1011 sync header, data MSB-first,
// optional even parity and GAP_BITS idle guard cycles.
// Define SEQ_GEN_PARITY_EN to append the even-parity bit after the data.
module seq_gen_1011 #(
    parameter int WIDTH    = 8,
    parameter int GAP_BITS = 0
) (
    input logic          clk_i,
    input logic          reset_n_i,
    seq_gen_1011_if.slave bus
);
    localparam int M1   = WIDTH > 4 ? WIDTH : 4;
    localparam int MAXV = M1 > GAP_BITS ? M1 : GAP_BITS;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [3:0]    SYNC_PAT = 4'b1011;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] SYNC_LD  = CW'(3);
    localparam logic [CW-1:0] DATA_LD  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;

    localparam state_t POST_ST = GAP_BITS > 0 ? GAP : IDLE;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             par_bit;
`ifdef SEQ_GEN_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bus.data_ready = (state_q == IDLE);
    assign bus.out_bit    = out_bit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;

    // Next state, counter reload/countdown and the outputs for the cycle being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
`ifdef SEQ_GEN_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (bus.data_valid) begin
                state_d = SYNC;
                cnt_d   = SYNC_LD;
                sh_d    = bus.data_in;
`ifdef SEQ_GEN_PARITY_EN
                par_d   = ^bus.data_in;
`endif
            end
            SYNC: if (cnt_q == '0) begin
                state_d = DATA;
                cnt_d   = DATA_LD;
            end else begin
                cnt_d = cnt_q - ONE;
            end
            DATA: if (cnt_q == '0) begin
`ifdef SEQ_GEN_PARITY_EN
                state_d = PARITY;
                cnt_d   = '0;
`else
                state_d = POST_ST;
                cnt_d   = GAP_LD;
`endif
            end else begin
                cnt_d = cnt_q - ONE;
                sh_d  = sh_q << 1;
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                state_d = POST_ST;
                cnt_d   = GAP_LD;
            end
`endif
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - ONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef SEQ_GEN_PARITY_EN
        par_bit      = (state_d == PARITY) & par_d;
        frame_done_d = (state_d == PARITY);
`else
        par_bit      = 1'b0;
        frame_done_d = (state_d == DATA) && (cnt_d == '0);
`endif
        out_valid_d = state_d inside {SYNC, DATA, PARITY};
        out_bit_d   = (state_d == SYNC) ? SYNC_PAT[cnt_d[1:0]] :
                      (state_d == DATA) ? sh_d[WIDTH-1] : par_bit;
    end

    // State, datapath and registered serial outputs; reset aborts any frame at once
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
`ifdef SEQ_GEN_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_gen_1011.sv
// tb_seq_gen_1011: scoreboard bench for seq_gen_1011 (WIDTH=8, GAP_BITS=3)
module tb_seq_gen_1011;
    localparam int W   = 8;
    localparam int GAP = 3;
`ifdef SEQ_GEN_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L = 4 + W + P;

    typedef struct {
        logic b;
        logic fd;
        int   cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   det_n = 0;
    int   det_cyc = -1;
    logic [3:0] hist = 4'b0;
    bit   mon_en = 0;
    exp_t exp_q[$];

    seq_gen_1011_if #(.WIDTH(W)) bus ();

    seq_gen_1011 #(.WIDTH(W), .GAP_BITS(GAP)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference frame: sync header, data MSB-first, optional even parity, done on last bit
    task automatic push_frame(input logic [W-1:0] w, input int k);
        logic bits[$];
        bits = {1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = W - 1; i >= 0; i--) bits.push_back(w[i]);
        if (P == 1) bits.push_back(^w);
        for (int i = 0; i < bits.size(); i++)
            exp_q.push_back('{bits[i], (i == bits.size() - 1), k + i});
    endtask

    // Must be called at a negedge; returns the handshake edge index k
    task automatic send(input logic [W-1:0] w, input bit hold, output int k);
        int n;
        n = 0;
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        while (!bus.data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.data_ready) begin
            chk("handshake_timeout", 0, 1);
            bus.data_valid = 1'b0;
            k = -1;
        end else begin
            k = cyc + 1;
            push_frame(w, k);
            @(negedge clk);
            chk("ready_drop", bus.data_ready, 0);
            if (!hold) bus.data_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (GAP + 2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every valid bit, otherwise the line must be quiet
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            hist = {hist[2:0], bus.out_bit};
            if (hist == 4'b1011) begin
                det_n++;
                det_cyc = cyc + 1;
            end
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_bit", bus.out_bit, e.b);
                    chk("frame_done", bus.frame_done, e.fd);
                    chk("bit_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_out", {bus.out_bit, bus.frame_done}, 0);
            end
        end
    end

    initial begin
        int k, k1, k2, kp, n;
        bit hold, prev_hold;
        reset_n        = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bit", bus.out_bit, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_ready", bus.data_ready, 1);
        reset_n = 1'b1;
        mon_en  = 1;
        @(negedge clk);

        send(8'hA5, 0, k);
        drain();
        send(8'h01, 0, k);
        drain();
        send(8'hA5, 0, k);
        drain();

        // Back-to-back with valid held high; second frame is the all-zero payload
        send(8'hFF, 1, k1);
        repeat (5) @(negedge clk);
        det_n = 0;
        send(8'h00, 1, k2);
        bus.data_valid = 1'b0;
        chk("b2b_spacing", k2 - k1, L + GAP + 1);
        drain();
        chk("detector_count", det_n, 1);
        chk("detector_cycle", det_cyc, k2 + 4);

        // Word offered mid-frame must be ignored
        send(8'hC3, 0, k);
        repeat (5) @(negedge clk);
        bus.data_in    = 8'h3C;
        bus.data_valid = 1'b1;
        chk("busy_ready", bus.data_ready, 0);
        @(negedge clk);
        bus.data_valid = 1'b0;
        drain();

        // Reset on the 6th bit of a frame
        send(8'h96, 0, k);
        n = 0;
        while (cyc < k + 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_bit", bus.out_bit, 0);
        chk("abort_frame_done", bus.frame_done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send(8'h5A, 0, k);
        drain();

        // Randomized words, random idle spacing and held-valid bursts
        prev_hold = 0;
        kp = 0;
        for (int i = 0; i < 24; i++) begin
            hold = 1'($urandom_range(0, 1));
            if (prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            else repeat ($urandom_range(0, 20)) @(negedge clk);
            send(W'($urandom), hold, k);
            if (prev_hold) chk("burst_spacing", k - kp, L + GAP + 1);
            prev_hold = hold;
            kp = k;
        end
        bus.data_valid = 1'b0;
        drain();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
